// File: rtl/maze_pkg.sv
// Shared types and heading helpers for the maze walker.
// Headings use screen coordinates: SOUTH is +y, so the right turn from SOUTH is WEST.
package maze_pkg;

  typedef enum logic [1:0] {EAST, WEST, SOUTH, NORTH} heading_t;

  typedef enum logic [2:0] {IDLE, FIND_EXIT, FIND_ENTRY, WALK, DONE, FAIL} state_t;

  localparam logic HAND_RIGHT = 1'b0;
  localparam logic HAND_LEFT  = 1'b1;

  function automatic heading_t turn_right(heading_t h);
    case (h)
      NORTH:   return EAST;
      EAST:    return SOUTH;
      SOUTH:   return WEST;
      default: return NORTH;
    endcase
  endfunction

  function automatic heading_t turn_left(heading_t h);
    case (h)
      NORTH:   return WEST;
      WEST:    return SOUTH;
      SOUTH:   return EAST;
      default: return NORTH;
    endcase
  endfunction

endpackage

// File: rtl/maze_next_move.sv
// Combinational wall-follower step: picks the first open neighbour in hand priority order.
module maze_next_move
  import maze_pkg::*;
#(
  parameter int SIZE = 9,
  parameter int N    = $clog2(SIZE)
) (
  input  logic [SIZE-1:0][SIZE-1:0] maze,
  input  logic [N-1:0]              x,
  input  logic [N-1:0]              y,
  input  heading_t                  heading,
  input  logic                      hand,
  output logic                      valid,
  output logic [N-1:0]              nx,
  output logic [N-1:0]              ny,
  output heading_t                  nheading
);

  localparam logic [N-1:0] LAST = N'(SIZE - 1);

  logic [N-1:0] xp, xm, yp, ym;
  logic [3:0]   open_dir;
  heading_t     cand [4];

  always_comb begin
    // Neighbour indices are clamped so the maze is never indexed outside the grid;
    // the edge tests below mark those clamped neighbours as walls.
    xp = (x == LAST) ? x : x + 1'b1;
    xm = (x == '0)   ? x : x - 1'b1;
    yp = (y == LAST) ? y : y + 1'b1;
    ym = (y == '0)   ? y : y - 1'b1;

    open_dir        = '0;
    open_dir[EAST]  = (x != LAST) && !maze[y][xp];
    open_dir[WEST]  = (x != '0)   && !maze[y][xm];
    open_dir[SOUTH] = (y != LAST) && !maze[yp][x];
    open_dir[NORTH] = (y != '0)   && !maze[ym][x];

    cand[1] = heading;
    cand[3] = turn_right(turn_right(heading));
    if (hand == HAND_LEFT) begin
      cand[0] = turn_left(heading);
      cand[2] = turn_right(heading);
    end else begin
      cand[0] = turn_right(heading);
      cand[2] = turn_left(heading);
    end

    valid    = 1'b0;
    nheading = heading;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!valid && open_dir[cand[i]]) begin
        valid    = 1'b1;
        nheading = cand[i];
      end
    end

    nx = x;
    ny = y;
    if (valid) begin
      case (nheading)
        EAST:    nx = xp;
        WEST:    nx = xm;
        SOUTH:   ny = yp;
        default: ny = ym;
      endcase
    end
  end

endmodule

// File: rtl/maze_walker.sv
// Walks an SxS maze from the top-row opening to the bottom-row opening by wall following,
// recording visited cells and counting moves under a step budget.
module maze_walker
  import maze_pkg::*;
#(
  parameter int SIZE      = 9,
  parameter int N         = $clog2(SIZE),
  parameter int STEP_W    = 12,
  parameter int MAX_STEPS = 2**STEP_W - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      hand,
  input  logic [SIZE-1:0][SIZE-1:0] maze,
  output logic [N-1:0]              x,
  output logic [N-1:0]              y,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [STEP_W-1:0]         steps,
  output logic [SIZE-1:0][SIZE-1:0] path
);

  localparam logic [N-1:0]      LAST       = N'(SIZE - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_t                    state_q, state_d;
  heading_t                  heading_q, heading_d;
  logic                      hand_q, hand_d;
  logic [N-1:0]              col_q, col_d;
  logic [N-1:0]              exit_q, exit_d;
  logic [N-1:0]              x_q, x_d, y_q, y_d;
  logic                      busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [STEP_W-1:0]         steps_q, steps_d;
  logic [SIZE-1:0][SIZE-1:0] path_q, path_d;

  logic                      mv_valid;
  logic [N-1:0]              mv_x, mv_y;
  heading_t                  mv_heading;
  logic [STEP_W-1:0]         steps_inc;
  logic                      at_exit;

  maze_next_move #(.SIZE(SIZE), .N(N)) u_next (
    .maze     (maze),
    .x        (x_q),
    .y        (y_q),
    .heading  (heading_q),
    .hand     (hand_q),
    .valid    (mv_valid),
    .nx       (mv_x),
    .ny       (mv_y),
    .nheading (mv_heading)
  );

  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    hand_d    = hand_q;
    col_d     = col_q;
    exit_d    = exit_q;
    x_d       = x_q;
    y_d       = y_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fail_d    = fail_q;
    steps_d   = steps_q;
    path_d    = path_q;
    steps_inc = steps_q + 1'b1;
    at_exit   = (mv_y == LAST) && (mv_x == exit_q);

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          path_d  = '0;
          steps_d = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          col_d   = '0;
          hand_d  = hand;
          state_d = FIND_EXIT;
        end
      end
      FIND_EXIT: begin
        if (!maze[LAST][col_q]) begin
          exit_d  = col_q;
          col_d   = '0;
          state_d = FIND_ENTRY;
        end else if (col_q == LAST) begin
          busy_d  = 1'b0;
          fail_d  = 1'b1;
          state_d = FAIL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      FIND_ENTRY: begin
        if (!maze[0][col_q]) begin
          x_d              = col_q;
          y_d              = '0;
          path_d[0][col_q] = 1'b1;
          heading_d        = SOUTH;
          state_d          = WALK;
        end else if (col_q == LAST) begin
          busy_d  = 1'b0;
          fail_d  = 1'b1;
          state_d = FAIL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      WALK: begin
        // A move that lands on the exit is always taken, even if it uses the last step.
        if (!mv_valid || (!at_exit && steps_inc == STEP_LIMIT)) begin
          busy_d  = 1'b0;
          fail_d  = 1'b1;
          state_d = FAIL;
        end else begin
          x_d                = mv_x;
          y_d                = mv_y;
          heading_d          = mv_heading;
          path_d[mv_y][mv_x] = 1'b1;
          steps_d            = steps_inc;
          if (at_exit) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      heading_q <= SOUTH;
      hand_q    <= HAND_RIGHT;
      col_q     <= '0;
      exit_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      steps_q   <= '0;
      path_q    <= '0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      hand_q    <= hand_d;
      col_q     <= col_d;
      exit_q    <= exit_d;
      x_q       <= x_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      steps_q   <= steps_d;
      path_q    <= path_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign fail  = fail_q;
  assign steps = steps_q;
  assign path  = path_q;

endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker: two 5x5 instances (12-bit and 4-bit step counters) share stimulus
// and are compared every cycle against a cell-level wall-follower model.
module tb_maze_walker;

  localparam int SZ = 5;

  typedef struct {
    bit        busy;
    bit        done;
    bit        fail;
    int        x;
    int        y;
    int        steps;
    bit [24:0] path;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        hand_i = 1'b0;
  logic [24:0] maze_i = '1;

  logic [2:0]  x0, y0, x1, y1;
  logic        busy0, done0, fail0, busy1, done1, fail1;
  logic [11:0] steps0;
  logic [3:0]  steps1;
  logic [24:0] path0, path1;

  int total = 0;
  int bad   = 0;

  int px0 = 0, py0 = 0, px1 = 0, py1 = 0;
  int fd0, ff0, fd1, ff1;
  snap_t s0;
  snap_t tmp_q[$];
  snap_t exp0[$];
  snap_t exp1[$];

  // Clockwise direction table: 0=N, 1=E, 2=S, 3=W; turn offsets in priority order.
  int dxt[4]  = '{0, 1, 0, -1};
  int dyt[4]  = '{-1, 0, 1, 0};
  int rord[4] = '{1, 0, 3, 2};
  int lord[4] = '{3, 0, 1, 2};

  always #5 clk = ~clk;

  maze_walker #(.SIZE(SZ), .STEP_W(12)) dut0 (
    .clk(clk), .rst(rst), .start(start_i), .hand(hand_i), .maze(maze_i),
    .x(x0), .y(y0), .busy(busy0), .done(done0), .fail(fail0),
    .steps(steps0), .path(path0)
  );

  maze_walker #(.SIZE(SZ), .STEP_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_i), .hand(hand_i), .maze(maze_i),
    .x(x1), .y(y1), .busy(busy1), .done(done1), .fail(fail1),
    .steps(steps1), .path(path1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic snap_t samp(input int which);
    snap_t s;
    if (which == 0) begin
      s.busy = busy0; s.done = done0; s.fail = fail0;
      s.x = int'(x0); s.y = int'(y0); s.steps = int'(steps0); s.path = path0;
    end else begin
      s.busy = busy1; s.done = done1; s.fail = fail1;
      s.x = int'(x1); s.y = int'(y1); s.steps = int'(steps1); s.path = path1;
    end
    return s;
  endfunction

  task automatic cmp_snap(input string tag, input snap_t a, input snap_t e);
    chk({tag, "_busy"},  a.busy,  e.busy);
    chk({tag, "_done"},  a.done,  e.done);
    chk({tag, "_fail"},  a.fail,  e.fail);
    chk({tag, "_x"},     a.x,     e.x);
    chk({tag, "_y"},     a.y,     e.y);
    chk({tag, "_steps"}, a.steps, e.steps);
    chk({tag, "_path"},  a.path,  e.path);
  endtask

  // Cycle-by-cycle expected outputs, one entry per clock edge starting at the accepting edge.
  task automatic model_run(input bit [24:0] w, input bit hd, input int maxs,
                           inout int px, inout int py);
    snap_t sn;
    int e, s, cx, cy, d, st, nd, nx, ny, dd, tx, ty;
    bit found;
    tmp_q.delete();
    sn.busy = 1; sn.done = 0; sn.fail = 0;
    sn.x = px; sn.y = py; sn.steps = 0; sn.path = '0;
    tmp_q.push_back(sn);
    e = -1;
    for (int c = 0; c < SZ && e < 0; c++) begin
      if (!w[(SZ-1)*SZ + c]) e = c;
      else if (c == SZ-1) begin sn.busy = 0; sn.fail = 1; end
      tmp_q.push_back(sn);
    end
    if (e >= 0) begin
      s = -1;
      for (int c = 0; c < SZ && s < 0; c++) begin
        if (!w[c]) begin
          s = c; sn.x = c; sn.y = 0; sn.path[c] = 1'b1;
        end else if (c == SZ-1) begin
          sn.busy = 0; sn.fail = 1;
        end
        tmp_q.push_back(sn);
      end
      if (s >= 0) begin
        cx = s; cy = 0; d = 2; st = 0;
        forever begin
          found = 0; nd = 0; nx = 0; ny = 0;
          for (int t = 0; t < 4; t++) begin
            if (!found) begin
              dd = (d + (hd ? lord[t] : rord[t])) % 4;
              tx = cx + dxt[dd];
              ty = cy + dyt[dd];
              if (tx >= 0 && tx < SZ && ty >= 0 && ty < SZ && !w[ty*SZ + tx]) begin
                found = 1; nd = dd; nx = tx; ny = ty;
              end
            end
          end
          if (!found || (!(nx == e && ny == SZ-1) && st + 1 == maxs)) begin
            sn.busy = 0; sn.fail = 1;
            tmp_q.push_back(sn);
            break;
          end
          cx = nx; cy = ny; d = nd; st++;
          sn.x = nx; sn.y = ny; sn.steps = st; sn.path[ny*SZ + nx] = 1'b1;
          if (nx == e && ny == SZ-1) begin
            sn.busy = 0; sn.done = 1;
            tmp_q.push_back(sn);
            break;
          end
          tmp_q.push_back(sn);
        end
      end
    end
    px = sn.x;
    py = sn.y;
  endtask

  task automatic run_case(input string nm, input bit [24:0] w, input bit hd, input int pulse_k);
    int n;
    snap_t a;
    model_run(w, hd, 4095, px0, py0); exp0 = tmp_q;
    model_run(w, hd, 15,   px1, py1); exp1 = tmp_q;
    n = (exp0.size() > exp1.size()) ? exp0.size() : exp1.size();
    fd0 = -1; ff0 = -1; fd1 = -1; ff1 = -1;
    maze_i = w; hand_i = hd; start_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start_i = (k == pulse_k);
      a = samp(0);
      if (k == 0) s0 = a;
      if (a.done && fd0 < 0) fd0 = k;
      if (a.fail && ff0 < 0) ff0 = k;
      if (k < exp0.size()) cmp_snap({nm, "_w12"}, a, exp0[k]);
      a = samp(1);
      if (a.done && fd1 < 0) fd1 = k;
      if (a.fail && ff1 < 0) ff1 = k;
      if (k < exp1.size()) cmp_snap({nm, "_w4"}, a, exp1[k]);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  // Maze rows, bit x of each row = wall at column x; packed as {row4,row3,row2,row1,row0}.
  localparam bit [24:0] CORR   = {5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
  localparam bit [24:0] LSHAPE = {5'b01111, 5'b01111, 5'b01111, 5'b01111, 5'b00000};
  localparam bit [24:0] SPUR   = {5'b01111, 5'b01101, 5'b01101, 5'b01101, 5'b00000};
  localparam bit [24:0] NOEXIT = {5'b11111, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
  localparam bit [24:0] BOXED  = {5'b11110, 5'b11111, 5'b11111, 5'b11111, 5'b10111};
  localparam bit [24:0] LOOP   = {5'b01111, 5'b11111, 5'b11111, 5'b11100, 5'b11100};

  initial begin
    repeat (2) @(negedge clk);
    cmp_snap("reset_w12", samp(0), '{0, 0, 0, 0, 0, 0, 25'd0});
    cmp_snap("reset_w4",  samp(1), '{0, 0, 0, 0, 0, 0, 25'd0});
    rst = 1'b0;

    run_case("corridor", CORR, 1'b0, 3);
    chk("corridor_latency", fd0, 10);
    chk("corridor_steps", steps0, 4);
    chk("corridor_x", x0, 2);
    chk("corridor_y", y0, 4);
    chk("corridor_path", path0, {5{5'b00100}});

    run_case("lshape_r", LSHAPE, 1'b0, -1);
    chk("restart_path_cleared", s0.path, 0);
    chk("restart_steps_cleared", s0.steps, 0);
    chk("lshape_r_steps", steps0, 8);
    chk("lshape_r_done", done0, 1);

    run_case("lshape_l", LSHAPE, 1'b1, -1);
    chk("lshape_l_steps", steps0, 8);

    run_case("spur_r", SPUR, 1'b0, -1);
    chk("spur_r_steps", steps0, 14);
    chk("spur_r_spurbit", path0[11], 1);
    chk("spur_r_w4_done", done1, 1);

    run_case("spur_l", SPUR, 1'b1, -1);
    chk("spur_l_steps", steps0, 8);
    chk("spur_l_spurbit", path0[11], 0);

    run_case("noexit", NOEXIT, 1'b0, -1);
    chk("noexit_fail_cycle", ff0, 5);
    chk("noexit_steps", steps0, 0);
    chk("noexit_path", path0, 0);

    run_case("boxed", BOXED, 1'b0, -1);
    chk("boxed_fail_cycle", ff0, 6);
    chk("boxed_steps", steps0, 0);
    chk("boxed_path", path0, 25'd8);

    run_case("loop", LOOP, 1'b0, -1);
    chk("loop_w4_fail_cycle", ff1, 21);
    chk("loop_w4_steps", steps1, 14);
    chk("loop_w4_fail", fail1, 1);
    chk("loop_w12_steps", steps0, 4094);

    maze_i = CORR; hand_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("prerst_busy", busy0, 1);
    chk("prerst_steps", steps0, 1);
    #2 rst = 1'b1;
    #1;
    cmp_snap("midrst_w12", samp(0), '{0, 0, 0, 0, 0, 0, 25'd0});
    cmp_snap("midrst_w4",  samp(1), '{0, 0, 0, 0, 0, 0, 25'd0});
    @(negedge clk);
    rst = 1'b0;
    px0 = 0; py0 = 0; px1 = 0; py1 = 0;

    run_case("after_rst", CORR, 1'b0, -1);
    chk("after_rst_latency", fd0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
